// File: rtl/instr_pkg.sv
// Shared LEGv8 encoding constants: op codes, opcode fields and immediate range limits.
// Imported by the encoder and by the decode/sign-extend logic.
package instr_pkg;

  typedef enum logic [3:0] {
    LSL  = 4'd0,
    LSR  = 4'd1,
    MUL  = 4'd2,
    ADDS = 4'd3,
    SUBS = 4'd4,
    LDUR = 4'd5,
    STUR = 4'd6,
    CBZ  = 4'd7,
    BLT  = 4'd8,
    B    = 4'd9,
    ADDI = 4'd10
  } op_e;

  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_ADDS = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS = 11'b11101011000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_BLT  = 8'b01010100;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;

  localparam logic [4:0]  COND_LT  = 5'b01011;

  localparam logic [63:0]        SHAMT_MAX = 64'd63;
  localparam logic [63:0]        ADDI_MAX  = 64'd4095;
  localparam logic signed [63:0] D_MIN     = -64'sd256;
  localparam logic signed [63:0] D_MAX     = 64'sd255;
  localparam logic signed [63:0] CB_MIN    = -64'sd262144;
  localparam logic signed [63:0] CB_MAX    = 64'sd262143;
  localparam logic signed [63:0] B_MIN     = -64'sd33554432;
  localparam logic signed [63:0] B_MAX     = 64'sd33554431;

  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_OP    = 2'b10;

  function automatic logic in_srange(input logic signed [63:0] v,
                                     input logic signed [63:0] lo,
                                     input logic signed [63:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry FIFO carrying {addr, instr}; simultaneous push/pop allowed when full.
module instr_fifo2 #(
  parameter int W     = 44,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic [1:0]   count,
  output logic         valid
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_pop;
  logic         do_push;

  assign valid   = (count != 2'd0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign data_out = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (DEPTH == 2 && count <= 2'd2);
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs op/registers/immediate into a LEGv8 word, range-checks the immediate,
// and queues accepted words with an auto-incrementing byte address.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       emit_count
);

  op_e               op;
  logic [10:0]       r_opc;
  logic [31:0]       instr;
  logic              op_ok;
  logic              imm_ok;
  logic              accept;
  logic              push;
  logic              reject;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr;

  assign op       = op_e'(in_op);
  assign in_ready = (count < 2'd2);
  assign accept   = in_valid && in_ready;
  assign push     = accept && !clear && op_ok && imm_ok;
  assign reject   = accept && !clear && !(op_ok && imm_ok);

  always_comb begin
    r_opc = '0;
    case (op)
      LSL:     r_opc = OPC_LSL;
      LSR:     r_opc = OPC_LSR;
      MUL:     r_opc = OPC_MUL;
      ADDS:    r_opc = OPC_ADDS;
      SUBS:    r_opc = OPC_SUBS;
      default: r_opc = '0;
    endcase
  end

  // Field extraction mirrors what the decoder pulls back out of each format.
  always_comb begin
    instr  = '0;
    op_ok  = 1'b1;
    imm_ok = 1'b0;
    case (op)
      LSL, LSR, MUL, ADDS, SUBS: begin
        instr  = {r_opc, in_rm, in_imm[5:0], in_rn, in_rd};
        imm_ok = (in_imm <= SHAMT_MAX);
      end
      LDUR, STUR: begin
        instr  = {(op == LDUR) ? OPC_LDUR : OPC_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
        imm_ok = in_srange(in_imm, D_MIN, D_MAX);
      end
      CBZ: begin
        instr  = {OPC_CBZ, in_imm[18:0], in_rd};
        imm_ok = in_srange(in_imm, CB_MIN, CB_MAX);
      end
      BLT: begin
        instr  = {OPC_BLT, in_imm[18:0], COND_LT};
        imm_ok = in_srange(in_imm, CB_MIN, CB_MAX);
      end
      B: begin
        instr  = {OPC_B, in_imm[25:0]};
        imm_ok = in_srange(in_imm, B_MIN, B_MAX);
      end
      ADDI: begin
        instr  = {OPC_ADDI, in_imm[11:0], in_rn, in_rd};
        imm_ok = (in_imm <= ADDI_MAX);
      end
      default: op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr       <= '0;
      emit_count <= '0;
      err        <= 1'b0;
      err_code   <= '0;
    end else if (clear) begin
      addr       <= '0;
      emit_count <= '0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      err <= reject;
      if (reject) err_code <= op_ok ? ERR_RANGE : ERR_OP;
      if (push) begin
        addr       <= addr + ADDR_W'(4);
        emit_count <= emit_count + 16'd1;
      end
    end
  end

  instr_fifo2 #(
    .W     (ADDR_W + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear),
    .push     (push),
    .pop      (out_ready),
    .data_in  ({addr, instr}),
    .data_out ({out_addr, out_instr}),
    .count    (count),
    .valid    (out_valid)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clear, in_valid, out_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [63:0] in_imm;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [11:0] out_addr;
  logic [1:0]  err_code;
  logic [15:0] emit_count;

  logic        in_ready_4, out_valid_4, err_4;
  logic [31:0] out_instr_4;
  logic [3:0]  out_addr_4;
  logic [1:0]  err_code_4;
  logic [15:0] emit_count_4;

  instr_encoder #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_code(err_code), .emit_count(emit_count)
  );

  instr_encoder #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_4),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid_4), .out_ready(out_ready), .out_instr(out_instr_4), .out_addr(out_addr_4),
    .err(err_4), .err_code(err_code_4), .emit_count(emit_count_4)
  );

  typedef struct {
    int unsigned addr;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  int unsigned m_addr, m_emit;
  logic        m_err;
  logic [1:0]  m_code;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_enc(input logic [3:0] op, input logic [4:0] rd, rn, rm,
                                    input logic [63:0] imm, output logic legal,
                                    output logic [1:0] code, output logic [31:0] w);
    longint s;
    logic [31:0] opc;
    s = imm;
    legal = 1'b0;
    code = 2'b01;
    w = '0;
    opc = '0;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
        case (op)
          4'd0: opc = 32'b11010011011;
          4'd1: opc = 32'b11010011010;
          4'd2: opc = 32'b10011011000;
          4'd3: opc = 32'b10101011000;
          default: opc = 32'b11101011000;
        endcase
        legal = (imm <= 64'd63);
        w = (opc << 21) | (32'(rm) << 16) | (32'(imm % 64) << 10) | (32'(rn) << 5) | 32'(rd);
      end
      4'd5, 4'd6: begin
        opc = (op == 4'd5) ? 32'b11111000010 : 32'b11111000000;
        legal = (s >= -256) && (s <= 255);
        w = (opc << 21) | (32'(imm & 64'h1FF) << 12) | (32'(rn) << 5) | 32'(rd);
      end
      4'd7, 4'd8: begin
        opc = (op == 4'd7) ? 32'b10110100 : 32'b01010100;
        legal = (s >= -(64'sd1 << 18)) && (s < (64'sd1 << 18));
        w = (opc << 24) | (32'(imm & 64'h7FFFF) << 5) | ((op == 4'd7) ? 32'(rd) : 32'd11);
      end
      4'd9: begin
        legal = (s >= -(64'sd1 << 25)) && (s < (64'sd1 << 25));
        w = 32'h1400_0000 | 32'(imm & 64'h3FF_FFFF);
      end
      4'd10: begin
        legal = (imm <= 64'd4095);
        w = (32'h244 << 22) | (32'(imm & 64'hFFF) << 10) | (32'(rn) << 5) | 32'(rd);
      end
      default: code = 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = 0;
    m_emit = 0;
    m_err = 1'b0;
    m_code = 2'b00;
  endtask

  task automatic check_outputs();
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_instr", out_instr, q[0].instr);
      check("out_addr", out_addr, q[0].addr % 4096);
      check("out_addr_w4", out_addr_4, q[0].addr % 16);
    end else begin
      check("out_instr_empty", out_instr, 0);
    end
    check("err", err, m_err);
    check("err_code", err_code, m_code);
    check("emit_count", emit_count, m_emit % 65536);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] rd, rn, rm,
                       input logic [63:0] imm);
    in_valid = v;
    in_op = op;
    in_rd = rd;
    in_rn = rn;
    in_rm = rm;
    in_imm = imm;
  endtask

  // One clock: inputs already driven after a falling edge; outputs checked at the next falling edge.
  task automatic cycle();
    logic legal;
    logic [1:0] code;
    logic [31:0] w;
    logic acc, pop;
    check("in_ready", in_ready, q.size() < 2);
    acc = in_valid && (q.size() < 2);
    pop = out_ready && (q.size() > 0);
    model_enc(in_op, in_rd, in_rn, in_rm, in_imm, legal, code, w);
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && legal) begin
        q.push_back('{addr: m_addr, instr: w});
        m_addr += 4;
        m_emit++;
      end
      m_err = acc && !legal;
      if (acc && !legal) m_code = code;
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [63:0] pick_imm(input logic [3:0] op);
    longint lo, hi;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin lo = 0; hi = 63; end
      4'd5, 4'd6: begin lo = -256; hi = 255; end
      4'd7, 4'd8: begin lo = -(64'sd1 << 18); hi = (64'sd1 << 18) - 1; end
      4'd9: begin lo = -(64'sd1 << 25); hi = (64'sd1 << 25) - 1; end
      4'd10: begin lo = 0; hi = 4095; end
      default: begin lo = 0; hi = 0; end
    endcase
    case ($urandom_range(0, 6))
      0: return lo;
      1: return hi;
      2: return lo - 1;
      3: return hi + 1;
      4, 5: return lo + longint'($urandom_range(0, 32'(hi - lo)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int unsigned exp4 [5] = '{0, 4, 8, 12, 0};
    reset = 1'b1;
    clear = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    check("reset_in_ready", in_ready, 1);
    reset = 1'b0;

    drive(1'b1, 4'd10, 5'd1, 5'd2, 5'd0, 64'd5);
    cycle();
    check("addi_word", out_instr, 32'h9100_1441);
    check("addi_addr", out_addr, 0);
    check("addi_emit", emit_count, 1);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;

    out_ready = 1'b1;
    drive(1'b1, 4'd5, 5'd3, 5'd4, 5'd0, -64'sd8);
    cycle();
    check("ldur_word", out_instr, 32'hF85F_8083);
    drive(1'b1, 4'd9, 5'd0, 5'd0, 5'd0, -64'sd1);
    cycle();
    check("b_word", out_instr, 32'h17FF_FFFF);
    check("b_addr", out_addr, 4);

    drive(1'b1, 4'd5, 5'd3, 5'd4, 5'd0, 64'd256);
    cycle();
    check("range_err", err, 1);
    check("range_code", err_code, 2'b01);
    check("range_nopush", emit_count, 2);
    drive(1'b1, 4'd13, 5'd0, 5'd0, 5'd0, 64'd0);
    cycle();
    check("op_code", err_code, 2'b10);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    cycle();
    check("err_pulse_end", err, 0);
    check("err_code_hold", err_code, 2'b10);

    clear = 1'b1;
    cycle();
    clear = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 64'd7);
    cycle();
    drive(1'b1, 4'd2, 5'd4, 5'd5, 5'd6, 64'd0);
    cycle();
    drive(1'b1, 4'd10, 5'd7, 5'd8, 5'd0, 64'd4095);
    cycle();
    check("full_in_ready", in_ready, 0);
    check("full_head_addr", out_addr, 0);
    out_ready = 1'b1;
    cycle();
    check("pop_head_addr", out_addr, 4);
    cycle();
    check("third_addr", out_addr, 8);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    cycle();

    clear = 1'b1;
    cycle();
    clear = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1'b1, 4'd9, 5'd0, 5'd0, 5'd0, 64'(i));
      cycle();
      check("wrap4_addr", out_addr_4, exp4[i]);
    end

    out_ready = 1'b0;
    drive(1'b1, 4'd6, 5'd9, 5'd10, 5'd0, 64'd17);
    cycle();
    cycle();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    #2 reset = 1'b1;
    #1 check("async_reset_valid", out_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_outputs();

    drive(1'b1, 4'd10, 5'd1, 5'd1, 5'd0, 64'd1);
    cycle();
    clear = 1'b1;
    drive(1'b1, 4'd10, 5'd2, 5'd2, 5'd0, 64'd2);
    cycle();
    clear = 1'b0;
    check("clear_empty", out_valid, 0);
    check("clear_emit", emit_count, 0);
    drive(1'b1, 4'd10, 5'd3, 5'd3, 5'd0, 64'd3);
    cycle();
    check("clear_addr0", out_addr, 0);

    for (int unsigned i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 10));
      drive($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 5'($urandom), pick_imm(op));
      out_ready = ($urandom_range(0, 9) < 6);
      clear = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
